// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: shared offsets, access-size codes, STATUS layout and FSM states
// for the memory-mapped UART transmitter.
package mmio_uart_pkg;
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV    = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_CNT   = 4;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction
endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// sync_fifo: single-clock FIFO; a pop in the same cycle frees a slot so a push
// into a full FIFO is still accepted.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          wr, rd;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];
    assign wr      = push_i && (!full_o || pop_i);
    assign rd      = pop_i && !empty_o;

    always_ff @(posedge clk)
        if (wr) mem_q[wptr_q] <= wdata_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr) wptr_q <= wptr_q + AW'(1);
            if (rd) rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter (TXDATA/STATUS/DIV registers)
// sitting beside dmem on the data-memory port.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter logic [15:0] BAUD_DIV   = 16'd868,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [1:0]  be,
    output logic [31:0] rd,
    output logic        tx,
    output logic        busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel, push, pop, push_ok, tick, full, empty, ovf_q;
    logic [1:0]    off;
    logic [7:0]    head, shift_q, status;
    logic [CW-1:0] count;
    logic [15:0]   div_q, per_q, cnt_q;
    logic [2:0]    idx_q;
    logic          tx_q, busy_q;
    state_e        state_q;
    logic          unused;

    assign sel     = a[31:4] == BASE_ADDR[31:4];
    assign off     = a[3:2];
    assign push    = we && sel && off == OFF_TXDATA;
    assign tick    = cnt_q == 16'd0;
    assign pop     = !empty && (state_q == S_IDLE || (state_q == S_STOP && tick));
    assign push_ok = push && (!full || pop);
    assign unused  = ^{a[1:0], wd[31:16]};

    always_comb begin
        status                = '0;
        status[ST_FULL]       = full;
        status[ST_EMPTY]      = empty;
        status[ST_BUSY]       = busy_q;
        status[ST_OVF]        = ovf_q;
        status[ST_CNT +: 3]   = 3'(count);
    end

    assign rd   = !sel                ? 32'd0 :
                  off == OFF_STATUS   ? {24'd0, status} :
                  off == OFF_DIV      ? {16'd0, div_q} : 32'd0;
    assign tx   = tx_q;
    assign busy = busy_q;

    sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wd[7:0]),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= BAUD_DIV;
            ovf_q <= 1'b0;
        end else begin
            if (push && full && !pop)
                ovf_q <= 1'b1;
            else if (we && sel && off == OFF_STATUS && wd[3])
                ovf_q <= 1'b0;
            if (we && sel && off == OFF_DIV) begin
                if (be == SZ_BYTE)
                    div_q[7:0] <= wd[7:0];
                else if (be == SZ_HALF || be == SZ_WORD)
                    div_q <= wd[15:0];
            end
        end
    end

    // cnt_q reloads on every bit boundary; a pop relatches the period so DIV only affects new frames
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            per_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            busy_q <= 1'b1;
            cnt_q  <= tick ? per_q - 16'd1 : cnt_q - 16'd1;
            if (pop) begin
                state_q <= S_START;
                shift_q <= head;
                per_q   <= eff_div(div_q);
                cnt_q   <= eff_div(div_q) - 16'd1;
                tx_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: busy_q <= push_ok;
                    S_START: if (tick) begin
                        state_q <= S_DATA;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                    S_DATA: if (tick) begin
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
                    S_STOP: if (tick) begin
                        state_q <= S_IDLE;
                        busy_q  <= push_ok;
                    end
                endcase
            end
        end
    end
endmodule
